piso_serializer: RTL and testbench

Parallel-in/serial-out front end that feeds the serial bit stream consumed by the divisible-by-5 FSM. It accepts a WIDTH-bit word through a valid/ready handshake and emits it one bit per enabled clock, MSB first by default. Each bit is framed with valid/first/last flags, so the downstream FSM can qualify its input and restart its remainder per word. Back-to-back words stream with no idle bubble.

---
 rtl/piso_serializer.sv | 86 ++++++++
 tb/tb_piso_serializer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/piso_serializer.sv
// piso_serializer
// Parallel-in/serial-out front end for a bit-serial consumer.
// Accepts a WIDTH-bit word over a valid/ready handshake and shifts it out
// one bit per ser_en=1 cycle, each bit framed with valid/first/last flags.
// Back-to-back words stream with no idle gap when the next word is offered
// on the last enabled bit of the current one.
//
// Build option: define SER_LSB_FIRST_EN to transmit bit 0 first.
// Default build (macro undefined) transmits MSB first.
module piso_serializer #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_valid,
   input  logic [WIDTH-1:0] load_data,
   output logic             load_ready,
   input  logic             ser_en,
   output logic             ser_out,
   output logic             ser_valid,
   output logic             ser_first,
   output logic             ser_last,
   output logic             busy
);

   localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_SHIFT = 1'b1;

   logic [0:0]       state;
   logic [WIDTH-1:0] shreg;
   logic [IDX_W-1:0] idx;
   logic [WIDTH-1:0] shreg_adv;
   logic             accept;

   // Output framing is a pure function of state and bit index.
   assign ser_valid = (state == ST_SHIFT);
   assign busy      = ser_valid;
   assign ser_first = ser_valid && (idx == '0);
   assign ser_last  = ser_valid && (idx == IDX_LAST);

   // Ready depends only on state and ser_en, never on load_valid, so there is
   // no combinational loop through an upstream that waits on ready.
   assign load_ready = (state == ST_IDLE) || (ser_last && ser_en);
   assign accept     = load_valid && load_ready;

`ifdef SER_LSB_FIRST_EN
   // Bit 0 leaves first: shift right, present the LSB.
   assign shreg_adv = {1'b0, shreg[WIDTH-1:1]};
   assign ser_out   = ser_valid && shreg[0];
`else
   // MSB leaves first: shift left, present the MSB.
   assign shreg_adv = {shreg[WIDTH-2:0], 1'b0};
   assign ser_out   = ser_valid && shreg[WIDTH-1];
`endif

   // Load, advance, or retire the in-flight word.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         // NOTE: the shift register is a plain register (not a memory), so it
         // is reset along with the control state; an aborted word leaves nothing behind.
         state <= ST_IDLE;
         shreg <= '0;
         idx   <= '0;
      end else if (accept) begin
         // Covers both a load from IDLE and a reload on the last enabled bit.
         state <= ST_SHIFT;
         shreg <= load_data;
         idx   <= '0;
      end else if ((state == ST_SHIFT) && ser_en) begin
         if (idx == IDX_LAST) begin
            state <= ST_IDLE;
            shreg <= '0;
            idx   <= '0;
         end else begin
            shreg <= shreg_adv;
            idx   <= idx + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer
// Self-checking bench for piso_serializer: directed scenarios followed by
// randomized traffic, all checked cycle by cycle against a word/position
// model plus a word-level scoreboard that reassembles the serial stream.
// Honours SER_LSB_FIRST_EN for the expected bit order.
module tb_piso_serializer;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         load_valid;
   logic [W-1:0] load_data;
   logic         load_ready;
   logic         ser_en;
   logic         ser_out;
   logic         ser_valid;
   logic         ser_first;
   logic         ser_last;
   logic         busy;

   int errors = 0;
   int checks = 0;

   // Reference model: the word being sent and which transmit position is shown.
   bit           m_active;
   logic [W-1:0] m_word;
   int           m_pos;

   // Word-level scoreboard and downstream divisible-by-5 consumer.
   logic [W-1:0] acc_q[$];
   logic [W-1:0] asm_word;
   int           asm_cnt;
   int           rem5;
   int           valid_cnt;

   piso_serializer #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst        (rst),
      .load_valid (load_valid),
      .load_data  (load_data),
      .load_ready (load_ready),
      .ser_en     (ser_en),
      .ser_out    (ser_out),
      .ser_valid  (ser_valid),
      .ser_first  (ser_first),
      .ser_last   (ser_last),
      .busy       (busy)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic bit model_bit();
      if (!m_active) return 1'b0;
`ifdef SER_LSB_FIRST_EN
      return m_word[m_pos];
`else
      return m_word[W-1-m_pos];
`endif
   endfunction

   task automatic model_reset();
      m_active = 1'b0;
      m_word   = '0;
      m_pos    = 0;
      acc_q.delete();
      asm_word = '0;
      asm_cnt  = 0;
      rem5     = 0;
   endtask

   // One clock cycle: drive inputs, check outputs mid-cycle, consume the
   // shown bit, then advance the model across the rising edge.
   task automatic step(input bit lv, input logic [W-1:0] ld, input bit en);
      bit         exp_ready;
      bit         acc;
      logic [5:0] exp_outs;
      load_valid = lv;
      load_data  = ld;
      ser_en     = en;
      #1;
      exp_ready = !m_active || (m_pos == W-1 && en);
      exp_outs  = {exp_ready, model_bit(), m_active, m_active && m_pos == 0,
                   m_active && m_pos == W-1, m_active};
      check("outs{rdy,out,vld,fst,lst,busy}",
            {26'd0, load_ready, ser_out, ser_valid, ser_first, ser_last, busy},
            {26'd0, exp_outs});
      if (ser_valid) valid_cnt++;
      acc = lv && exp_ready;

      // Downstream view: a bit is consumed when valid and enabled.
      if (ser_valid && en) begin
         if (ser_first) begin
            asm_cnt = 0;
            rem5    = 0;
         end
`ifdef SER_LSB_FIRST_EN
         asm_word[asm_cnt] = ser_out;
`else
         asm_word = {asm_word[W-2:0], ser_out};
`endif
         rem5 = (rem5 * 2 + int'(ser_out)) % 5;
         asm_cnt++;
         if (ser_last) begin
            if (acc_q.size() == 0) begin
               check("word_q_nonempty", 32'd0, 32'd1);
            end else begin
               check("word", {24'd0, asm_word}, {24'd0, acc_q.pop_front()});
            end
            check("word_bits", asm_cnt, W);
         end
      end

      @(posedge clk);
      #1;
      if (acc) acc_q.push_back(ld);
      if (m_active && en) begin
         if (m_pos == W-1) begin
            m_active = acc;
            m_word   = ld;
            m_pos    = 0;
         end else begin
            m_pos++;
         end
      end else if (!m_active && acc) begin
         m_active = 1'b1;
         m_word   = ld;
         m_pos    = 0;
      end
   endtask

   initial begin
      rst        = 1'b0;
      load_valid = 1'b0;
      load_data  = '0;
      ser_en     = 1'b0;
      model_reset();
      valid_cnt  = 0;
      #3;
      check("reset_outs{out,vld,fst,lst,busy}",
            {27'd0, ser_out, ser_valid, ser_first, ser_last, busy}, 32'd0);
      check("reset_ready", {31'd0, load_ready}, 32'd1);
      @(negedge clk);
      rst = 1'b1;

      // Single word, ser_en high, then idle.
      step(1'b1, 8'hB5, 1'b1);
      for (int i = 0; i < W + 2; i++) step(1'b0, 8'h00, 1'b1);

      // Back-to-back B5 then 0A with load_valid held: 16 contiguous bits.
      step(1'b1, 8'hB5, 1'b1);
      valid_cnt = 0;
      for (int i = 0; i < W; i++) step(1'b1, 8'h0A, 1'b1);
      for (int i = 0; i < W; i++) step(1'b0, 8'h00, 1'b1);
      check("b2b_valid_bits", valid_cnt, 2 * W);
`ifndef SER_LSB_FIRST_EN
      check("div5_of_0A", {31'd0, rem5 == 0}, 32'd1);
`endif
      step(1'b0, 8'h00, 1'b1);

      // Stall for 3 cycles after bit 3.
      step(1'b1, 8'hB5, 1'b1);
      for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1);
      for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0);
      for (int i = 0; i < W; i++) step(1'b0, 8'h00, 1'b1);

      // 8'hFF offered while busy: only accepted on the last-bit cycle.
      step(1'b1, 8'hB5, 1'b1);
      for (int i = 0; i < 2 * W; i++) step(1'b1, 8'hFF, 1'b1);
      for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1);

      // Asynchronous reset mid-word, between clock edges.
      step(1'b1, 8'hB5, 1'b1);
      for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1);
      rst = 1'b0;
      #1;
      check("async_rst_outs{out,vld,fst,lst,busy}",
            {27'd0, ser_out, ser_valid, ser_first, ser_last, busy}, 32'd0);
      check("async_rst_ready", {31'd0, load_ready}, 32'd1);
      model_reset();
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < W + 2; i++) step(1'b0, 8'h00, 1'b1);

      // Randomized traffic.
      for (int i = 0; i < 600; i++) begin
         step(1'($urandom_range(0, 1)), W'($urandom), ($urandom_range(0, 3) != 0));
      end
      // Drain whatever is still in flight.
      for (int i = 0; i < 2 * W; i++) step(1'b0, 8'h00, 1'b1);
      check("drained_queue", acc_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
